// File: rtl/fft8_w8_rotator.sv
// Radix-8 FFT inner twiddle rotator: multiplies each sample of an 8-sample frame
// by W8^r (r from the index table) through a three-stage, ED-gated pipeline.
module fft8_w8_rotator #(
  parameter int nb = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ED,
  input  logic               START,
  input  logic signed [nb+1:0] DR,
  input  logic signed [nb+1:0] DI,
  output logic signed [nb+1:0] DOR,
  output logic signed [nb+1:0] DOI,
  output logic               RDY
);

  localparam int W  = nb + 2;
  localparam int WS = nb + 3;
  localparam int WP = nb + 12;
  localparam logic signed [WP-1:0] K = WP'(181);

  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          r_d;

  logic signed [W-1:0]  x1_q, y1_q;
  logic [1:0]           r1_q;
  logic                 rdy1_q;

  logic signed [W-1:0]  x2_q, y2_q;
  logic signed [WS-1:0] s2_q, d2_q, s2_d, d2_d;
  logic [1:0]           r2_q;
  logic                 rdy2_q;

  logic signed [W-1:0]  m_s, m_d;
  logic signed [W-1:0]  dor_q, doi_q, dor_d, doi_d;
  logic                 rdy_q;

  // Index of the sample being accepted now, and its twiddle exponent.
  always_comb begin
    cnt_d = START ? 3'd0 : cnt_q + 3'd1;
    case (cnt_d)
      3'd3:    r_d = 2'd1;
      3'd5:    r_d = 2'd2;
      3'd7:    r_d = 2'd3;
      default: r_d = 2'd0;
    endcase
  end

  always_comb begin
    s2_d = WS'(x1_q) + WS'(y1_q);
    d2_d = WS'(y1_q) - WS'(x1_q);
  end

  // M(v) = floor(v*181/256); the final narrowing wraps without saturation.
  always_comb begin
    m_s   = W'((WP'(s2_q) * K) >>> 8);
    m_d   = W'((WP'(d2_q) * K) >>> 8);
    dor_d = x2_q;
    doi_d = y2_q;
    case (r2_q)
      2'd1: begin
        dor_d = m_s;
        doi_d = m_d;
      end
      2'd2: begin
        dor_d = y2_q;
        doi_d = -x2_q;
      end
      2'd3: begin
        dor_d = m_d;
        doi_d = -m_s;
      end
      default: begin
        dor_d = x2_q;
        doi_d = y2_q;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      r1_q   <= '0;
      rdy1_q <= 1'b0;
      x2_q   <= '0;
      y2_q   <= '0;
      s2_q   <= '0;
      d2_q   <= '0;
      r2_q   <= '0;
      rdy2_q <= 1'b0;
      dor_q  <= '0;
      doi_q  <= '0;
      rdy_q  <= 1'b0;
    end else if (ED) begin
      cnt_q  <= cnt_d;
      x1_q   <= DR;
      y1_q   <= DI;
      r1_q   <= r_d;
      rdy1_q <= START;
      x2_q   <= x1_q;
      y2_q   <= y1_q;
      s2_q   <= s2_d;
      d2_q   <= d2_d;
      r2_q   <= r1_q;
      rdy2_q <= rdy1_q;
      dor_q  <= dor_d;
      doi_q  <= doi_d;
      rdy_q  <= rdy2_q;
    end
  end

  assign DOR = dor_q;
  assign DOI = doi_q;
  assign RDY = rdy_q;

endmodule

// File: tb/tb_fft8_w8_rotator.sv
// Bench for fft8_w8_rotator: frame-level complex-arithmetic model checked every
// cycle, plus directed vectors with hand-computed literal outputs.
module tb_fft8_w8_rotator;

  localparam int NB = 16;
  localparam int W  = NB + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                ed = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] dr = '0;
  logic signed [W-1:0] di = '0;
  logic signed [W-1:0] dor, doi;
  logic                rdy;

  int n_tests = 0;
  int n_fail  = 0;

  fft8_w8_rotator #(.nb(NB)) dut (
    .CLK(clk), .RST(rst), .ED(ed), .START(start),
    .DR(dr), .DI(di), .DOR(dor), .DOI(doi), .RDY(rdy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [2*W:0] exp_q[$];
  logic [2*W:0] cur_exp = '0;
  int           idx_m = 0;
  int           rtab[8] = '{0, 0, 0, 1, 0, 2, 0, 3};

  function automatic longint mfun(input longint v);
    return longint'($floor(real'(v) * 181.0 / 256.0));
  endfunction

  function automatic longint wrapw(input longint v);
    longint m, h, t;
    m = longint'(1) << W;
    h = longint'(1) << (W - 1);
    t = ((v % m) + m) % m;
    if (t >= h) t = t - m;
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    longint x, y, er, ei;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      idx_m   = 0;
      cur_exp = '0;
    end else if (ed) begin
      idx_m = start ? 0 : (idx_m + 1) % 8;
      x = longint'(dr);
      y = longint'(di);
      case (rtab[idx_m])
        1:       begin er = mfun(x + y); ei = mfun(y - x);  end
        2:       begin er = y;           ei = -x;           end
        3:       begin er = mfun(y - x); ei = -mfun(x + y); end
        default: begin er = x;           ei = y;            end
      endcase
      exp_q.push_back({start, W'(wrapw(er)), W'(wrapw(ei))});
      cur_exp = exp_q.pop_front();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    n_tests++;
    if ({rdy, dor, doi} !== cur_exp) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got rdy=%0b dor=%0d doi=%0d exp rdy=%0b dor=%0d doi=%0d",
               $time, rdy, dor, doi, cur_exp[2*W], $signed(cur_exp[2*W-1:W]),
               $signed(cur_exp[W-1:0]));
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic step(input logic e, input logic s, input int x, input int y);
    @(negedge clk);
    ed    = e;
    start = s;
    dr    = W'(x);
    di    = W'(y);
  endtask

  task automatic chk(input string nm, input int er, input int ei, input logic erdy);
    logic [2*W:0] e;
    e = {erdy, W'(er), W'(ei)};
    n_tests++;
    if ({rdy, dor, doi} !== e) begin
      n_fail++;
      $display("FAIL %s got rdy=%0b dor=%0d doi=%0d exp rdy=%0b dor=%0d doi=%0d",
               nm, rdy, dor, doi, erdy, er, ei);
    end
  endtask

  int lit_r[8] = '{1000, 1000, 1000, 707, 1000, 0, 1000, -708};
  int lit_i[8] = '{0, 0, 0, -708, 0, -1000, 0, -707};
  int vx[8]    = '{100, -300, 7, 1000, -1, 1234, 0, -200};
  int vy[8]    = '{-50, 200, 9, 500, -1, -567, 0, -100};

  initial begin
    int k;
    logic e;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", 0, 0, 1'b0);
    rst = 1'b0;

    // pre-START traffic: RDY must stay low
    for (int t = 0; t < 4; t++) step(1'b1, 1'b0, 0, 0);

    // frame of (1000,0)
    for (int t = 0; t <= 10; t++) begin
      step(1'b1, t == 0, (t < 8) ? 1000 : 0, 0);
      if (t >= 3) chk($sformatf("frame_idx%0d", t - 3), lit_r[t-3], lit_i[t-3], t == 3);
    end

    // varied complex vectors
    for (int t = 0; t <= 10; t++) begin
      step(1'b1, t == 0, (t < 8) ? vx[t] : 0, (t < 8) ? vy[t] : 0);
      if (t == 3)  chk("vec_idx0", 100, -50, 1'b1);
      if (t == 6)  chk("vec_idx3_r1", 1060, -354, 1'b0);
      if (t == 7)  chk("vec_idx4_r0", -1, -1, 1'b0);
      if (t == 8)  chk("vec_idx5_r2", -567, -1234, 1'b0);
      if (t == 10) chk("vec_idx7_r3", 70, 213, 1'b0);
    end

    // stall after third sample
    k = 0;
    for (int t = 0; t <= 12; t++) begin
      e = !(t == 3 || t == 4);
      step(e, e && (k == 0), (k < 8) ? 1000 : 0, 0);
      if (e) k++;
      if (t >= 3 && t <= 5) chk($sformatf("stall_hold%0d", t), 1000, 0, 1'b1);
      if (t == 8)  chk("stall_idx3", 707, -708, 1'b0);
      if (t == 10) chk("stall_idx5", 0, -1000, 1'b0);
    end

    // restart on index 5
    for (int t = 0; t <= 11; t++) begin
      step(1'b1, t == 0 || t == 5, (t < 5) ? 500 : 1000, (t < 5) ? 300 : 0);
      if (t == 6)  chk("restart_inflight_idx3", 565, -142, 1'b0);
      if (t == 8)  chk("restart_sample", 1000, 0, 1'b1);
      if (t == 9)  chk("restart_next_idx1", 1000, 0, 1'b0);
      if (t == 11) chk("restart_idx3", 707, -708, 1'b0);
    end

    // wrap without START, plus negation wrap at r=2
    for (int t = 0; t <= 18; t++) begin
      step(1'b1, t == 0, (t == 13) ? -131072 : ((t < 16) ? 1000 : 0), 0);
      if (t == 11) chk("wrap_idx8", 1000, 0, 1'b0);
      if (t == 14) chk("wrap_idx11", 707, -708, 1'b0);
      if (t == 16) chk("wrap_neg_min", 0, -131072, 1'b0);
      if (t == 18) chk("wrap_idx15", -708, -707, 1'b0);
    end

    // asynchronous reset mid-frame
    for (int t = 0; t <= 4; t++) step(1'b1, t == 0, 1000, 0);
    #2 rst = 1'b1;
    #1 chk("async_reset", 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 300, 400);
    for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 0, 0);
    chk("rdy_after_reset", 300, 400, 1'b1);
    repeat (3) step(1'b1, 1'b0, 0, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
